// File: rtl/barrel_pkg.sv
// Shared constants and thread-ID type for the barrel RISC-V core pipeline.
package barrel_pkg;

    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam int unsigned NUM_THREADS   = 8;
    localparam int unsigned BITS_THREADS  = $clog2(NUM_THREADS);

    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000;
    localparam logic [ADDRESS_WIDTH-1:0] THREAD_STRIDE = 32'h0000_1000;

    typedef logic [BITS_THREADS-1:0] tid_t;

endpackage

// File: rtl/rr_thread_picker.sv
// Round-robin thread selector: rotate the enable mask so the thread after
// i_last sits at bit 0, priority-encode, then rotate the index back.
module rr_thread_picker
    import barrel_pkg::*;
#(
    parameter  int unsigned NUM_THREADS = barrel_pkg::NUM_THREADS,
    localparam int unsigned BITS        = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] i_thread_en,
    input  logic [BITS-1:0]        i_last,
    output logic [BITS-1:0]        o_sel,
    output logic                   o_any
);

    logic [BITS-1:0]          w_base;
    logic [2*NUM_THREADS-1:0] w_dbl;
    logic [NUM_THREADS-1:0]   w_rot;
    logic [BITS-1:0]          w_idx;
    logic                     w_found;

    assign w_base = i_last + BITS'(1);
    assign w_dbl  = {i_thread_en, i_thread_en};
    // Bit i of w_rot is thread (last+1+i) mod N, so i_last lands at the top and is scanned last.
    assign w_rot  = w_dbl[w_base +: NUM_THREADS];

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (!w_found && w_rot[i]) begin
                w_idx   = BITS'(i);
                w_found = 1'b1;
            end
        end
    end

    assign o_sel = w_base + w_idx;
    assign o_any = |i_thread_en;

endmodule

// File: rtl/barrel_fetch.sv
// Barrel fetch stage: one PC per hardware thread, round-robin issue over
// enabled threads, with same-cycle redirect bypass from execute.
module barrel_fetch
    import barrel_pkg::*;
#(
    parameter  int unsigned              ADDRESS_WIDTH = barrel_pkg::ADDRESS_WIDTH,
    parameter  int unsigned              NUM_THREADS   = barrel_pkg::NUM_THREADS,
    parameter  logic [ADDRESS_WIDTH-1:0] RESET_PC      = barrel_pkg::RESET_PC,
    parameter  logic [ADDRESS_WIDTH-1:0] THREAD_STRIDE = barrel_pkg::THREAD_STRIDE,
    localparam int unsigned              BITS_THREADS  = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic [NUM_THREADS-1:0]   thread_en,
    input  logic                     redirect_e,
    input  logic [BITS_THREADS-1:0]  redirect_tid_e,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc_e,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    output logic [BITS_THREADS-1:0]  tid_f,
    output logic                     valid_f
);

    logic [ADDRESS_WIDTH-1:0] r_pc [NUM_THREADS];
    logic [BITS_THREADS-1:0]  r_last;
    logic [ADDRESS_WIDTH-1:0] r_pc_f;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4_f;
    logic [BITS_THREADS-1:0]  r_tid_f;
    logic                     r_valid_f;

    logic [BITS_THREADS-1:0]  w_sel;
    logic                     w_any;
    logic                     w_issue;
    logic                     w_bypass;
    logic [ADDRESS_WIDTH-1:0] w_fetch_pc;
    logic [ADDRESS_WIDTH-1:0] w_next_pc;

    rr_thread_picker #(
        .NUM_THREADS (NUM_THREADS)
    ) u_picker (
        .i_thread_en (thread_en),
        .i_last      (r_last),
        .o_sel       (w_sel),
        .o_any       (w_any)
    );

    assign w_issue    = !stall_f && w_any;
    assign w_bypass   = redirect_e && (redirect_tid_e == w_sel);
    assign w_fetch_pc = w_bypass ? redirect_pc_e : r_pc[w_sel];
    assign w_next_pc  = w_fetch_pc + ADDRESS_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= RESET_PC + THREAD_STRIDE * ADDRESS_WIDTH'(t);
            end
            r_last       <= BITS_THREADS'(NUM_THREADS - 1);
            r_pc_f       <= '0;
            r_pc_plus4_f <= '0;
            r_tid_f      <= '0;
            r_valid_f    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pc_f       <= w_fetch_pc;
                r_pc_plus4_f <= w_next_pc;
                r_tid_f      <= w_sel;
                r_valid_f    <= 1'b1;
                r_pc[w_sel]  <= w_next_pc;
                r_last       <= w_sel;
            end else if (!stall_f) begin
                r_valid_f <= 1'b0;
            end
            // A redirect consumed by the bypass above is already folded into pc+4.
            if (redirect_e && !(w_issue && w_bypass)) begin
                r_pc[redirect_tid_e] <= redirect_pc_e;
            end
        end
    end

    assign pc_f       = r_pc_f;
    assign pc_plus4_f = r_pc_plus4_f;
    assign tid_f      = r_tid_f;
    assign valid_f    = r_valid_f;

endmodule

// File: tb/tb_barrel_fetch.sv
// Self-checking bench for barrel_fetch: directed scenarios plus randomized
// traffic compared against a scan-based behavioural model.
module tb_barrel_fetch;

    localparam int unsigned NT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic [7:0]  thread_en;
    logic        redirect_e;
    logic [2:0]  redirect_tid_e;
    logic [31:0] redirect_pc_e;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [2:0]  tid_f;
    logic        valid_f;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] m_pc [NT];
    int unsigned m_last;
    logic [31:0] m_pc_f, m_p4;
    int unsigned m_tid;
    logic        m_valid;

    barrel_fetch #(
        .ADDRESS_WIDTH (32),
        .NUM_THREADS   (8),
        .RESET_PC      (32'h0000_0000),
        .THREAD_STRIDE (32'h0000_1000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .thread_en      (thread_en),
        .redirect_e     (redirect_e),
        .redirect_tid_e (redirect_tid_e),
        .redirect_pc_e  (redirect_pc_e),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f),
        .tid_f          (tid_f),
        .valid_f        (valid_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned t = 0; t < NT; t++) m_pc[t] = t * 32'h1000;
        m_last  = NT - 1;
        m_pc_f  = '0;
        m_p4    = '0;
        m_tid   = 0;
        m_valid = 1'b0;
    endtask

    // Next thread in rotation after m_last under the current mask; NT if none enabled.
    function automatic int unsigned peek_sel();
        for (int unsigned k = 1; k <= NT; k++) begin
            if (thread_en[(m_last + k) % NT]) return (m_last + k) % NT;
        end
        return NT;
    endfunction

    task automatic model_edge();
        int unsigned sel;
        logic [31:0] fpc;
        bit          issued;
        bit          consumed;
        sel      = peek_sel();
        issued   = !stall_f && (sel != NT);
        consumed = 1'b0;
        if (issued) begin
            if (redirect_e && redirect_tid_e == sel) begin
                fpc      = redirect_pc_e;
                consumed = 1'b1;
            end else begin
                fpc = m_pc[sel];
            end
            m_pc_f    = fpc;
            m_p4      = fpc + 32'd4;
            m_tid     = sel;
            m_valid   = 1'b1;
            m_pc[sel] = fpc + 32'd4;
            m_last    = sel;
        end else if (!stall_f) begin
            m_valid = 1'b0;
        end
        if (redirect_e && !consumed) m_pc[redirect_tid_e] = redirect_pc_e;
    endtask

    task automatic compare_model();
        check("pc_f", pc_f, m_pc_f);
        check("pc_plus4_f", pc_plus4_f, m_p4);
        check("tid_f", {29'd0, tid_f}, m_tid);
        check("valid_f", {31'd0, valid_f}, {31'd0, m_valid});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        stall_f    = 1'b0;
        redirect_e = 1'b0;
        redirect_tid_e = '0;
        redirect_pc_e  = '0;
    endtask

    // Step until thread t issues; an expired budget counts as a failure.
    task automatic run_until_tid(input int unsigned t, input string tag);
        bit hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            step();
            if (valid_f && tid_f == t) hit = 1'b1;
        end
        check({tag, "_reached"}, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        int unsigned exp_seq [6];
        logic [31:0] hold_pc, hold_p4;
        logic [2:0]  hold_tid;
        logic        hold_v;

        rst       = 1'b1;
        thread_en = 8'hFF;
        idle_inputs();
        model_reset();
        #2;
        check("reset_pc_f", pc_f, 32'h0);
        check("reset_valid", {31'd0, valid_f}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All threads enabled, strict rotation from thread 0.
        for (int unsigned i = 0; i < 10; i++) begin
            step();
            check("rr_tid", {29'd0, tid_f}, i % 8);
            check("rr_pc", pc_f, (i < 8) ? i * 32'h1000 : 32'h4 + (i - 8) * 32'h1000);
            check("rr_valid", {31'd0, valid_f}, 32'd1);
        end

        // Sparse mask: last issued thread is 1, so rotation continues 2,5,0.
        thread_en = 8'b0010_0101;
        exp_seq   = '{2, 5, 0, 2, 5, 0};
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            check("mask_tid", {29'd0, tid_f}, exp_seq[i]);
        end
        thread_en = 8'h00;
        step();
        check("empty_valid", {31'd0, valid_f}, 32'd0);
        check("empty_tid_hold", {29'd0, tid_f}, 32'd0);
        step();
        thread_en = 8'b0010_0101;
        step();
        check("resume_tid", {29'd0, tid_f}, 32'd2);
        check("resume_valid", {31'd0, valid_f}, 32'd1);

        // Redirect thread 3 in the cycle it is selected (bypass).
        thread_en = 8'hFF;
        for (int n = 0; n < 10 && peek_sel() != 3; n++) step();
        redirect_e = 1'b1; redirect_tid_e = 3'd3; redirect_pc_e = 32'h0000_0800;
        step();
        idle_inputs();
        check("bypass_pc", pc_f, 32'h0000_0800);
        check("bypass_tid", {29'd0, tid_f}, 32'd3);
        run_until_tid(3, "bypass_next");
        check("bypass_next_pc", pc_f, 32'h0000_0804);

        // Redirect thread 6 during a 3-cycle stall.
        hold_pc = pc_f; hold_p4 = pc_plus4_f; hold_tid = tid_f; hold_v = valid_f;
        stall_f = 1'b1;
        redirect_e = 1'b1; redirect_tid_e = 3'd6; redirect_pc_e = 32'h0000_2000;
        for (int n = 0; n < 3; n++) begin
            step();
            redirect_e = 1'b0;
            check("stall_pc", pc_f, hold_pc);
            check("stall_p4", pc_plus4_f, hold_p4);
            check("stall_tid", {29'd0, tid_f}, {29'd0, hold_tid});
            check("stall_valid", {31'd0, valid_f}, {31'd0, hold_v});
        end
        idle_inputs();
        run_until_tid(6, "stall_redir");
        check("stall_redir_pc", pc_f, 32'h0000_2000);

        // PC+4 wrap on thread 1.
        for (int n = 0; n < 10 && peek_sel() == 1; n++) step();
        redirect_e = 1'b1; redirect_tid_e = 3'd1; redirect_pc_e = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        run_until_tid(1, "wrap");
        check("wrap_pc", pc_f, 32'hFFFF_FFFC);
        check("wrap_p4", pc_plus4_f, 32'h0);
        run_until_tid(1, "wrap_next");
        check("wrap_next_pc", pc_f, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            thread_en      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            stall_f        = ($urandom_range(0, 4) == 0);
            redirect_e     = ($urandom_range(0, 2) == 0);
            redirect_tid_e = 3'($urandom);
            redirect_pc_e  = $urandom;
            step();
        end
        idle_inputs();
        thread_en = 8'hFF;
        for (int n = 0; n < 3; n++) step();

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_pc", pc_f, 32'h0);
        check("async_p4", pc_plus4_f, 32'h0);
        check("async_tid", {29'd0, tid_f}, 32'd0);
        check("async_valid", {31'd0, valid_f}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_tid", {29'd0, tid_f}, 32'd0);
        check("post_rst_pc", pc_f, 32'h0);
        step();
        check("post_rst_pc1", pc_f, 32'h0000_1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
